// File: rtl/sys_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sys_ctrl_pkg
// Shared definitions for the command sequencer: command opcodes, FSM state
// encoding, fixed register-file addresses of the ALU operands and the ALU
// function-code width. No ports (package).
// -----------------------------------------------------------------------------
package sys_ctrl_pkg;

  // Command opcodes received as the first frame of a command
  localparam logic [7:0] CMD_WRITE   = 8'hAA;
  localparam logic [7:0] CMD_READ    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file slots that hold the ALU operands
  localparam int OPER_A_ADDR = 0;
  localparam int OPER_B_ADDR = 1;

  localparam int ALU_FUN_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_WAIT  = 4'd4,
    ST_ALU_A    = 4'd5,
    ST_ALU_B    = 4'd6,
    ST_ALU_FUNC = 4'd7,
    ST_ALU_WAIT = 4'd8,
    ST_TX_LO    = 4'd9,
    ST_TX_HI    = 4'd10
  } ctrl_state_t;

  // States in which an incoming RX byte cannot be consumed and is reported dropped
  function automatic logic drops_rx(input ctrl_state_t st);
    logic busy;
    case (st)
      ST_RD_WAIT, ST_ALU_WAIT, ST_TX_LO, ST_TX_HI: busy = 1'b1;
      default:                                     busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/ctrl_tx_pusher.sv
// -----------------------------------------------------------------------------
// ctrl_tx_pusher
// Pushes a 1- or 2-byte response into the TX FIFO, low byte first, honouring
// FIFO full back-pressure. A push is only issued from a cycle where the FIFO
// reports not-full; WR_INC/WR_DATA are registered.
// Ports:
//   CLK, Reset   clock and synchronous active-high reset
//   i_start      load i_data and begin a new push sequence
//   i_two        1: push two bytes (ALU result), 0: push one byte (read data)
//   i_data       response word, low byte pushed first
//   i_full       TX FIFO full
//   o_wr_data    FIFO write data (registered)
//   o_wr_inc     FIFO push strobe (registered)
//   o_fire       a byte is being launched this cycle
//   o_last       the byte being launched is the final one
// -----------------------------------------------------------------------------
module ctrl_tx_pusher #(
  parameter int width = 8
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               i_start,
  input  logic               i_two,
  input  logic [2*width-1:0] i_data,
  input  logic               i_full,
  output logic [width-1:0]   o_wr_data,
  output logic               o_wr_inc,
  output logic               o_fire,
  output logic               o_last
);

  logic [2*width-1:0] r_buf;
  logic [1:0]         r_cnt;

  assign o_fire = (r_cnt != 2'd0) && !i_full;
  assign o_last = (r_cnt == 2'd1);

  // Load the response, then shift bytes out one per non-full cycle
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_buf     <= '0;
      r_cnt     <= 2'd0;
      o_wr_data <= '0;
      o_wr_inc  <= 1'b0;
    end else begin
      o_wr_inc <= 1'b0;
      if (i_start) begin
        r_buf <= i_data;
        r_cnt <= i_two ? 2'd2 : 2'd1;
      end else if (o_fire) begin
        o_wr_inc  <= 1'b1;
        o_wr_data <= r_buf[width-1:0];
        r_buf     <= {{width{1'b0}}, r_buf[2*width-1:width]};
        r_cnt     <= r_cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// sys_cmd_ctrl
// Command sequencer between the UART RX byte stream and the register file,
// ALU and TX FIFO. Decodes 0xAA write, 0xBB read, 0xCC ALU with operands and
// 0xDD ALU without operands; returns read data / ALU results via the TX FIFO.
// All outputs are registered and clear to 0 on Reset.
// Ports:
//   CLK, Reset                  clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD         received byte and its valid strobe
//   RF_Address/WrEn/RdEn/WrData register-file access (strobes are 1 cycle)
//   RF_RdData, RF_RdData_VLD    register-file read return
//   ALU_EN, ALU_FUN             ALU request, ALU_EN held until result valid
//   ALU_OUT, ALU_OUT_VLD        ALU result return
//   CLK_GATE_EN                 ALU clock-gate enable during ALU commands
//   WR_DATA, WR_INC, FIFO_FULL  TX FIFO push interface
//   CMD_DROP                    pulse: RX byte discarded while busy
// -----------------------------------------------------------------------------
module sys_cmd_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter  int width  = 8,
  parameter  int depth  = 16,
  localparam int ADDR_W = $clog2(depth)
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic [width-1:0]     RX_P_DATA,
  input  logic                 RX_D_VLD,
  output logic [ADDR_W-1:0]    RF_Address,
  output logic                 RF_WrEn,
  output logic                 RF_RdEn,
  output logic [width-1:0]     RF_WrData,
  input  logic [width-1:0]     RF_RdData,
  input  logic                 RF_RdData_VLD,
  output logic                 ALU_EN,
  output logic [ALU_FUN_W-1:0] ALU_FUN,
  input  logic [2*width-1:0]   ALU_OUT,
  input  logic                 ALU_OUT_VLD,
  output logic                 CLK_GATE_EN,
  output logic [width-1:0]     WR_DATA,
  output logic                 WR_INC,
  input  logic                 FIFO_FULL,
  output logic                 CMD_DROP
);

  ctrl_state_t        r_state;
  logic               w_rd_done;
  logic               w_alu_done;
  logic               w_tx_start;
  logic [2*width-1:0] w_tx_data;
  logic               w_tx_fire;
  logic               w_tx_last;

  assign w_rd_done  = (r_state == ST_RD_WAIT)  && RF_RdData_VLD;
  assign w_alu_done = (r_state == ST_ALU_WAIT) && ALU_OUT_VLD;
  assign w_tx_start = w_rd_done || w_alu_done;
  // Read data occupies the low byte only; the pusher is told to send one byte
  assign w_tx_data  = w_alu_done ? ALU_OUT : {{width{1'b0}}, RF_RdData};

  ctrl_tx_pusher #(.width(width)) u_tx_pusher (
    .CLK       (CLK),
    .Reset     (Reset),
    .i_start   (w_tx_start),
    .i_two     (w_alu_done),
    .i_data    (w_tx_data),
    .i_full    (FIFO_FULL),
    .o_wr_data (WR_DATA),
    .o_wr_inc  (WR_INC),
    .o_fire    (w_tx_fire),
    .o_last    (w_tx_last)
  );

  // Command FSM with registered register-file / ALU / drop outputs
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      RF_Address  <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      CMD_DROP    <= 1'b0;
    end else begin
      RF_WrEn  <= 1'b0;
      RF_RdEn  <= 1'b0;
      CMD_DROP <= RX_D_VLD && drops_rx(r_state);
      case (r_state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            case (RX_P_DATA)
              width'(CMD_WRITE):   r_state <= ST_WR_ADDR;
              width'(CMD_READ):    r_state <= ST_RD_ADDR;
              width'(CMD_ALU_OP): begin
                r_state     <= ST_ALU_A;
                CLK_GATE_EN <= 1'b1;
              end
              width'(CMD_ALU_NOP): begin
                r_state     <= ST_ALU_FUNC;
                CLK_GATE_EN <= 1'b1;
              end
              default:             r_state <= ST_IDLE;
            endcase
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            RF_Address <= RX_P_DATA[ADDR_W-1:0];
            r_state    <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            RF_WrEn   <= 1'b1;
            RF_WrData <= RX_P_DATA;
            r_state   <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            RF_Address <= RX_P_DATA[ADDR_W-1:0];
            RF_RdEn    <= 1'b1;
            r_state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (RF_RdData_VLD) begin
            r_state <= ST_TX_LO;
          end
        end
        ST_ALU_A: begin
          if (RX_D_VLD) begin
            RF_Address <= ADDR_W'(OPER_A_ADDR);
            RF_WrEn    <= 1'b1;
            RF_WrData  <= RX_P_DATA;
            r_state    <= ST_ALU_B;
          end
        end
        ST_ALU_B: begin
          if (RX_D_VLD) begin
            RF_Address <= ADDR_W'(OPER_B_ADDR);
            RF_WrEn    <= 1'b1;
            RF_WrData  <= RX_P_DATA;
            r_state    <= ST_ALU_FUNC;
          end
        end
        ST_ALU_FUNC: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[ALU_FUN_W-1:0];
            ALU_EN  <= 1'b1;
            r_state <= ST_ALU_WAIT;
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            ALU_EN      <= 1'b0;
            CLK_GATE_EN <= 1'b0;
            r_state     <= ST_TX_LO;
          end
        end
        // The pusher holds the byte count, so it decides whether a high byte follows
        ST_TX_LO: begin
          if (w_tx_fire) begin
            r_state <= w_tx_last ? ST_IDLE : ST_TX_HI;
          end
        end
        ST_TX_HI: begin
          if (w_tx_fire) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          ALU_EN      <= 1'b0;
          CLK_GATE_EN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_cmd_ctrl
// Directed bench for sys_cmd_ctrl: write, read, ALU with and without operands,
// FIFO back-pressure, ignored/dropped bytes and reset in mid-command.
// -----------------------------------------------------------------------------
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [3:0]  RF_Address;
  logic        RF_WrEn;
  logic        RF_RdEn;
  logic [7:0]  RF_WrData;
  logic [7:0]  RF_RdData;
  logic        RF_RdData_VLD;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        CLK_GATE_EN;
  logic [7:0]  WR_DATA;
  logic        WR_INC;
  logic        FIFO_FULL;
  logic        CMD_DROP;

  always #5 CLK = ~CLK;

  sys_cmd_ctrl #(.width(8), .depth(16)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .RX_P_DATA     (RX_P_DATA),
    .RX_D_VLD      (RX_D_VLD),
    .RF_Address    (RF_Address),
    .RF_WrEn       (RF_WrEn),
    .RF_RdEn       (RF_RdEn),
    .RF_WrData     (RF_WrData),
    .RF_RdData     (RF_RdData),
    .RF_RdData_VLD (RF_RdData_VLD),
    .ALU_EN        (ALU_EN),
    .ALU_FUN       (ALU_FUN),
    .ALU_OUT       (ALU_OUT),
    .ALU_OUT_VLD   (ALU_OUT_VLD),
    .CLK_GATE_EN   (CLK_GATE_EN),
    .WR_DATA       (WR_DATA),
    .WR_INC        (WR_INC),
    .FIFO_FULL     (FIFO_FULL),
    .CMD_DROP      (CMD_DROP)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Event counters and the stream of pushed bytes, sampled mid-cycle
  int         wren_cnt  = 0;
  int         rden_cnt  = 0;
  int         inc_cnt   = 0;
  int         drop_cnt  = 0;
  int         full_push = 0;
  logic [7:0] pushed[$];

  always @(negedge CLK) begin
    if (RF_WrEn === 1'b1) wren_cnt++;
    if (RF_RdEn === 1'b1) rden_cnt++;
    if (CMD_DROP === 1'b1) drop_cnt++;
    if (WR_INC === 1'b1) begin
      inc_cnt++;
      pushed.push_back(WR_DATA);
      if (FIFO_FULL === 1'b1) full_push++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick(1);
    RX_D_VLD  = 1'b0;
    RX_P_DATA = 8'h00;
  endtask

  initial begin
    int s_wr;
    int s_rd;
    int s_inc;
    int s_drop;
    int base;

    Reset         = 1'b1;
    RX_P_DATA     = 8'h00;
    RX_D_VLD      = 1'b0;
    RF_RdData     = 8'h00;
    RF_RdData_VLD = 1'b0;
    ALU_OUT       = 16'h0000;
    ALU_OUT_VLD   = 1'b0;
    FIFO_FULL     = 1'b0;
    tick(3);
    check("reset_outputs",
          {RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN,
           CLK_GATE_EN, WR_DATA, WR_INC, CMD_DROP}, 32'h0);
    Reset = 1'b0;
    tick(1);

    // 1: write command AA,0A,FF
    s_wr = wren_cnt; s_inc = inc_cnt;
    send(8'hAA);
    send(8'h0A);
    check("wr_addr_latched", RF_Address, 32'hA);
    send(8'hFF);
    check("wr_wren", RF_WrEn, 32'h1);
    check("wr_addr", RF_Address, 32'hA);
    check("wr_data", RF_WrData, 32'hFF);
    tick(1);
    check("wr_wren_single", RF_WrEn, 32'h0);
    tick(3);
    check("wr_wren_count", wren_cnt - s_wr, 32'd1);
    check("wr_no_push", inc_cnt - s_inc, 32'd0);

    // 2: read command BB,0A, data returns two cycles later
    s_rd = rden_cnt; s_inc = inc_cnt; base = pushed.size();
    send(8'hBB);
    send(8'h0A);
    check("rd_rden", RF_RdEn, 32'h1);
    check("rd_addr", RF_Address, 32'hA);
    tick(1);
    check("rd_rden_single", RF_RdEn, 32'h0);
    RF_RdData = 8'hFF; RF_RdData_VLD = 1'b1;
    tick(1);
    RF_RdData_VLD = 1'b0;
    tick(1);
    check("rd_push_strobe", WR_INC, 32'h1);
    check("rd_push_data", WR_DATA, 32'hFF);
    tick(3);
    check("rd_push_count", inc_cnt - s_inc, 32'd1);
    check("rd_pushed_byte", pushed[base], 32'hFF);
    check("rd_rden_count", rden_cnt - s_rd, 32'd1);

    // 3: ALU with operands CC,0F,FF,00 -> result 0x010E
    s_wr = wren_cnt; s_inc = inc_cnt; base = pushed.size();
    send(8'hCC);
    check("alu_gate_on", CLK_GATE_EN, 32'h1);
    send(8'h0F);
    check("alu_opa_wren", RF_WrEn, 32'h1);
    check("alu_opa_addr", RF_Address, 32'h0);
    check("alu_opa_data", RF_WrData, 32'h0F);
    send(8'hFF);
    check("alu_opb_wren", RF_WrEn, 32'h1);
    check("alu_opb_addr", RF_Address, 32'h1);
    check("alu_opb_data", RF_WrData, 32'hFF);
    send(8'h00);
    check("alu_en_on", ALU_EN, 32'h1);
    check("alu_fun", ALU_FUN, 32'h0);
    check("alu_gate_func", CLK_GATE_EN, 32'h1);
    tick(2);
    check("alu_en_held", ALU_EN, 32'h1);
    ALU_OUT = 16'h010E; ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
    check("alu_en_off", ALU_EN, 32'h0);
    check("alu_gate_off", CLK_GATE_EN, 32'h0);
    tick(4);
    check("alu_push_count", inc_cnt - s_inc, 32'd2);
    check("alu_push_lo", pushed[base], 32'h0E);
    check("alu_push_hi", pushed[base+1], 32'h01);
    check("alu_wren_count", wren_cnt - s_wr, 32'd2);
    check("alu_gate_end", CLK_GATE_EN, 32'h0);

    // 4: ALU without operands DD,03 while the FIFO is full
    s_inc = inc_cnt; base = pushed.size();
    FIFO_FULL = 1'b1;
    send(8'hDD);
    check("nop_gate_on", CLK_GATE_EN, 32'h1);
    send(8'h03);
    check("nop_fun", ALU_FUN, 32'h3);
    check("nop_en", ALU_EN, 32'h1);
    tick(1);
    ALU_OUT = 16'h0400; ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
    tick(5);
    check("full_no_push", inc_cnt - s_inc, 32'd0);
    FIFO_FULL = 1'b0;
    tick(4);
    check("full_push_count", inc_cnt - s_inc, 32'd2);
    check("full_push_lo", pushed[base], 32'h00);
    check("full_push_hi", pushed[base+1], 32'h04);
    check("full_push_while_full", full_push, 32'd0);

    // 5: unknown byte in IDLE, then drops during ALU_WAIT and a stalled TX_LO
    s_wr = wren_cnt; s_rd = rden_cnt; s_inc = inc_cnt; s_drop = drop_cnt;
    send(8'h55);
    tick(2);
    check("junk_no_activity",
          {wren_cnt - s_wr, rden_cnt - s_rd, inc_cnt - s_inc, drop_cnt - s_drop}, 32'h0);
    check("junk_idle_outputs", {ALU_EN, CLK_GATE_EN}, 32'h0);
    base = pushed.size();
    send(8'hDD);
    send(8'h01);
    tick(1);
    send(8'h77);
    check("drop_alu_wait", CMD_DROP, 32'h1);
    check("drop_alu_en_kept", ALU_EN, 32'h1);
    tick(1);
    check("drop_single", CMD_DROP, 32'h0);
    FIFO_FULL = 1'b1;
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    tick(1);
    ALU_OUT_VLD = 1'b0;
    send(8'h88);
    check("drop_while_full", CMD_DROP, 32'h1);
    check("drop_full_no_push", WR_INC, 32'h0);
    tick(2);
    FIFO_FULL = 1'b0;
    tick(4);
    check("drop_push_count", inc_cnt - s_inc, 32'd2);
    check("drop_push_lo", pushed[base], 32'h34);
    check("drop_push_hi", pushed[base+1], 32'h12);
    check("drop_count", drop_cnt - s_drop, 32'd2);
    check("drop_full_push", full_push, 32'd0);

    // 6: reset in WR_DATA before the data byte, then a clean write
    s_wr = wren_cnt;
    send(8'hAA);
    send(8'h05);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("rst_mid_outputs", {RF_WrEn, RF_Address}, 32'h0);
    send(8'hFF);
    tick(2);
    check("rst_mid_no_write", wren_cnt - s_wr, 32'd0);
    send(8'hAA);
    send(8'h13);
    send(8'h5A);
    check("rst_after_wren", RF_WrEn, 32'h1);
    check("rst_after_addr", RF_Address, 32'h3);
    check("rst_after_data", RF_WrData, 32'h5A);
    tick(2);
    check("rst_after_count", wren_cnt - s_wr, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
